rr_arbiter_n: RTL and testbench
===============================

// Module: rr_arbiter_n
// PURPOSE
//   Parametrised round-robin arbiter with registered grant, valid/ready grant handshake
//   and optional bus lock. Generalises the combinational find-first-one select: search
//   starts at a rotating pointer and the winner is held stable until accepted.
//   Sits in front of shared CPU resources (AXI bridge read/write ports, cache refill path).
// PARAMETERS
//   N  32                   number of requesters, 2..64
//   W  (N<=2)?1:$clog2(N)   width of encoded grant index (derived; do not override)
// PORTS
//   clk         in   1  clock, all state updates on rising edge
//   reset       in   1  asynchronous, active-high reset
//   req         in   N  request vector; bit i = requester i
//   lock        in   1  sampled on grant acceptance; 1 = winner takes bus lock
//   gnt_ready   in   1  consumer accepts current grant
//   gnt_valid   out  1  grant offered
//   gnt_onehot  out  N  one-hot grant, equals 1<<gnt_idx when gnt_valid, else 0
//   gnt_idx     out  W  encoded grant index, always < N
//   locked      out  1  bus locked to gnt_idx owner
// BEHAVIOUR
//   - Reset: state=IDLE, ptr=0, gnt_valid=0, gnt_onehot=0, gnt_idx=0, locked=0.
//   - Winner: first set bit of req at index ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps).
//   - Outputs driven straight from registers, no combinational path from req to outputs.
//   - IDLE: gnt_valid=0. If |req, register the winner into gnt_idx and go to OFFER.
//     Latency: req high in cycle t -> gnt_valid high in cycle t+1.
//   - OFFER: gnt_valid=1; gnt_idx is held stable until accepted or withdrawn.
//     * gnt_ready=1 and lock=0: set ptr to gnt_idx+1 (N-1 wraps to 0).
//       Re-arbitrate in the same cycle with that ptr over current req.
//       If any req: stay in OFFER with the new winner, so back-to-back grants have no bubble.
//       Otherwise go to IDLE.
//     * gnt_ready=1 and lock=1: go to LOCKED; gnt_valid->0, locked->1, gnt_idx held.
//     * gnt_ready=0 and req[gnt_idx]=0: withdraw the grant. Go to IDLE, ptr unchanged,
//       so gnt_valid is 0 for one cycle.
//     * gnt_ready=0 and req[gnt_idx]=1: hold everything.
//   - LOCKED: gnt_valid=0, locked=1. Stays until req[gnt_idx] drops.
//     Then locked->0, ptr=gnt_idx+1 (wraps), go to IDLE.
//     Requests from other requesters are ignored while LOCKED.
//   - Simultaneous gnt_ready and req[gnt_idx] drop in OFFER: acceptance wins.
//   - A single active requester is re-granted on every acceptance.
//   - Reset asserted mid-grant or mid-lock: all outputs clear immediately (async).
//     The first grant after reset release starts from ptr=0.
//   - gnt_onehot and gnt_idx are registered together; any mismatch is a bug.
// CONFIGURATION
//   RR_ARB_LOCK_EN defined: lock input honoured, LOCKED state present.
//   RR_ARB_LOCK_EN undefined: lock ignored, LOCKED state not built, locked tied to 0.
//     Every acceptance behaves as lock=0.
// TESTING (N=4 unless noted)
//   1. Reset, then req=4'b1111 held, gnt_ready=1 every cycle -> gnt_idx 0,1,2,3,0,...
//      gnt_valid stays 1 from cycle 1 after the first req.
//   2. ptr=2 (after accepting idx 1), req=4'b0011 -> gnt_idx=0 (wraps past 2,3),
//      gnt_onehot=4'b0001.
//   3. req=4'b0100, gnt_ready=0 for 3 cycles, then req[2] drops -> gnt_idx stays 2,
//      gnt_valid=0 the cycle after the drop, ptr still 0.
//   4. RR_ARB_LOCK_EN: accept idx 1 with lock=1, req=4'b1011 held -> locked=1,
//      gnt_valid=0. req[1] drops -> locked=0, next grant idx 3.
//   5. Reset asserted during LOCKED -> locked, gnt_valid, gnt_onehot =0 with no clock edge.
//      With req=4'b1000 after release -> gnt_idx=3.
//   6. N=5, req=5'b10000 only -> gnt_idx=4. After accept ptr=0, and gnt_idx never reaches 5..7.

Source files
------------

// File: rtl/rr_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n_if
//   Request / grant bundle between N requesters and the round-robin arbiter.
//
//   Parameters
//     N           number of requesters (2..64); W is derived from it
//
//   Signals
//     req         N   request vector, bit i = requester i
//     lock        1   winner takes the bus lock when its grant is accepted
//     gnt_ready   1   consumer accepts the grant currently offered
//     gnt_valid   1   grant offered
//     gnt_onehot  N   one-hot grant, zero while no grant is offered
//     gnt_idx     W   encoded grant index, always < N
//     locked      1   bus locked to the gnt_idx owner
//
//   Modports
//     master      requester/consumer side (drives req, lock, gnt_ready)
//     slave       arbiter side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface rr_arbiter_n_if #(
    parameter int N = 32
);
    localparam int W = (N <= 2) ? 1 : $clog2(N);

    logic [N-1:0] req;
    logic         lock;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [N-1:0] gnt_onehot;
    logic [W-1:0] gnt_idx;
    logic         locked;

    modport master (
        output req,
        output lock,
        output gnt_ready,
        input  gnt_valid,
        input  gnt_onehot,
        input  gnt_idx,
        input  locked
    );

    modport slave (
        input  req,
        input  lock,
        input  gnt_ready,
        output gnt_valid,
        output gnt_onehot,
        output gnt_idx,
        output locked
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
//   Round-robin arbiter with a registered grant, a valid/ready grant handshake
//   and an optional bus lock. The search for a winner starts at a rotating
//   pointer and wraps; the winner is held stable until it is accepted or its
//   request is withdrawn. All outputs come straight from registers.
//
//   Parameters
//     N           number of requesters (2..64); W = encoded index width (derived)
//
//   Ports
//     clk         clock, rising edge
//     reset       asynchronous, active-high reset
//     bus         rr_arbiter_n_if.slave: req, lock, gnt_ready in;
//                 gnt_valid, gnt_onehot, gnt_idx, locked out
//
//   Configuration
//     RR_ARB_LOCK_EN  defined: lock is honoured and the LOCKED state exists.
//                     undefined: lock is ignored and locked is tied to 0.
// ---------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter  int N = 32,
    localparam int W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_n_if.slave bus
);

`ifdef RR_ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        LOCKED
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        OFFER
    } state_t;
`endif

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] idx_q;
    logic [N-1:0] onehot_q;
    logic         valid_q;
    logic [W-1:0] next_ptr;
    logic [W-1:0] win_from_ptr;
    logic [W-1:0] win_from_next;
    logic         req_any;
    logic         owner_req;
`ifdef RR_ARB_LOCK_EN
    logic         locked_q;
`else
    logic         unused_lock;
`endif

    // First set bit of r scanning start, start+1, ..., N-1, 0, ..., start-1.
    // start is always < N, so one conditional subtract is enough to wrap.
    function automatic logic [W-1:0] find_from(input logic [N-1:0] r,
                                               input logic [W-1:0] start);
        logic [W-1:0] win;
        logic         found;
        int           pos;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start) + i;
            if (pos >= N) pos = pos - N;
            if (!found && r[pos]) begin
                win   = W'(pos);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [N-1:0] onehot_of(input logic [W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Pointer after the current owner finishes; the last index wraps to 0
    // explicitly because N need not be a power of two.
    assign next_ptr      = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
    assign win_from_ptr  = find_from(bus.req, ptr);
    assign win_from_next = find_from(bus.req, next_ptr);
    assign req_any       = |bus.req;
    assign owner_req     = bus.req[idx_q];

    // Single state machine; grant index and one-hot are always written
    // together so they can never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
`ifdef RR_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        idx_q    <= win_from_ptr;
                        onehot_q <= onehot_of(win_from_ptr);
                        valid_q  <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.gnt_ready) begin
`ifdef RR_ARB_LOCK_EN
                        if (bus.lock) begin
                            valid_q  <= 1'b0;
                            onehot_q <= '0;
                            locked_q <= 1'b1;
                            state    <= LOCKED;
                        end else
`endif
                        begin
                            // Accept and re-arbitrate from the new pointer in
                            // the same cycle so back-to-back grants have no gap.
                            ptr <= next_ptr;
                            if (req_any) begin
                                idx_q    <= win_from_next;
                                onehot_q <= onehot_of(win_from_next);
                            end else begin
                                valid_q  <= 1'b0;
                                onehot_q <= '0;
                                state    <= IDLE;
                            end
                        end
                    end else if (!owner_req) begin
                        // Owner withdrew before acceptance: drop the offer,
                        // pointer untouched so it does not lose its turn order.
                        valid_q  <= 1'b0;
                        onehot_q <= '0;
                        state    <= IDLE;
                    end
                end
`ifdef RR_ARB_LOCK_EN
                LOCKED: begin
                    if (!owner_req) begin
                        locked_q <= 1'b0;
                        ptr      <= next_ptr;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_valid  = valid_q;
    assign bus.gnt_onehot = onehot_q;
    assign bus.gnt_idx    = idx_q;
`ifdef RR_ARB_LOCK_EN
    assign bus.locked     = locked_q;
`else
    assign bus.locked     = 1'b0;
    assign unused_lock    = bus.lock;
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_n
//   Drives an N=4 and an N=5 arbiter side by side with directed scenarios and
//   then random request/ready/lock traffic with occasional asynchronous
//   resets. A behavioural model (plain arithmetic over request vectors and a
//   turn pointer) predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_n;

`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk;
    logic reset;

    rr_arbiter_n_if #(.N(4)) a4 ();
    rr_arbiter_n_if #(.N(5)) a5 ();

    rr_arbiter_n #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(a4));
    rr_arbiter_n #(.N(5)) dut5 (.clk(clk), .reset(reset), .bus(a5));

    int checks = 0;
    int errors = 0;

    // Stimulus values held between cycles
    logic [63:0] r4, r5;
    logic        rdy4, rdy5, lk4, lk5;

    // Reference model state, index 0 = N=4 instance, 1 = N=5 instance
    int n_of[2] = '{4, 5};
    bit m_valid[2];
    bit m_locked[2];
    int m_ptr[2];
    int m_idx[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int ref_winner(input logic [63:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(p + k) % n]) return (p + k) % n;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_valid[u]  = 1'b0;
            m_locked[u] = 1'b0;
            m_ptr[u]    = 0;
            m_idx[u]    = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [63:0] r, input logic lk_in, input logic rdy_in);
        int n;
        n = n_of[u];
        if (m_locked[u]) begin
            if (!r[m_idx[u]]) begin
                m_locked[u] = 1'b0;
                m_ptr[u]    = (m_idx[u] + 1) % n;
            end
        end else if (m_valid[u]) begin
            if (rdy_in && LOCK_ON && lk_in) begin
                m_valid[u]  = 1'b0;
                m_locked[u] = 1'b1;
            end else if (rdy_in) begin
                m_ptr[u] = (m_idx[u] + 1) % n;
                if (r != 0) m_idx[u] = ref_winner(r, m_ptr[u], n);
                else        m_valid[u] = 1'b0;
            end else if (!r[m_idx[u]]) begin
                m_valid[u] = 1'b0;
            end
        end else if (r != 0) begin
            m_idx[u]   = ref_winner(r, m_ptr[u], n);
            m_valid[u] = 1'b1;
        end
    endtask

    function automatic logic [63:0] exp_onehot(input int u);
        return m_valid[u] ? (64'd1 << m_idx[u]) : 64'd0;
    endfunction

    task automatic compare_all();
        checkOutput("valid4",  64'(a4.gnt_valid),  64'(m_valid[0]));
        checkOutput("idx4",    64'(a4.gnt_idx),    64'(m_idx[0]));
        checkOutput("onehot4", 64'(a4.gnt_onehot), exp_onehot(0));
        checkOutput("locked4", 64'(a4.locked),     64'(m_locked[0]));
        checkOutput("valid5",  64'(a5.gnt_valid),  64'(m_valid[1]));
        checkOutput("idx5",    64'(a5.gnt_idx),    64'(m_idx[1]));
        checkOutput("onehot5", 64'(a5.gnt_onehot), exp_onehot(1));
        checkOutput("locked5", 64'(a5.locked),     64'(m_locked[1]));
        checkOutput("idx5_range", 64'(a5.gnt_idx < 3'd5), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        checkOutput({tag, "_valid4"},  64'(a4.gnt_valid),  64'd0);
        checkOutput({tag, "_onehot4"}, 64'(a4.gnt_onehot), 64'd0);
        checkOutput({tag, "_locked4"}, 64'(a4.locked),     64'd0);
        checkOutput({tag, "_idx4"},    64'(a4.gnt_idx),    64'd0);
        checkOutput({tag, "_valid5"},  64'(a5.gnt_valid),  64'd0);
        checkOutput({tag, "_onehot5"}, 64'(a5.gnt_onehot), 64'd0);
        checkOutput({tag, "_idx5"},    64'(a5.gnt_idx),    64'd0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model with
    // the same inputs, then compare 1ns after the edge.
    task automatic applyStimulus();
        a4.req       = r4[3:0];
        a4.lock      = lk4;
        a4.gnt_ready = rdy4;
        a5.req       = r5[4:0];
        a5.lock      = lk5;
        a5.gnt_ready = rdy5;
        @(posedge clk);
        model_step(0, r4, lk4, rdy4);
        model_step(1, r5, lk5, rdy5);
        #1;
        compare_all();
    endtask

    // Reset pulse placed between clock edges: outputs must clear with no edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_cleared(tag);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        r4 = '0; r5 = '0;
        rdy4 = 1'b0; rdy5 = 1'b0; lk4 = 1'b0; lk5 = 1'b0;
        a4.req = '0; a4.lock = 1'b0; a4.gnt_ready = 1'b0;
        a5.req = '0; a5.lock = 1'b0; a5.gnt_ready = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        #3;
        reset = 1'b0;

        // Rotation with everyone requesting; single N=5 requester re-granted
        $display("[TB] rotation with all requesters active");
        r4 = 64'hF; r5 = 64'h10; rdy4 = 1'b1; rdy5 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput("rot_valid", 64'(a4.gnt_valid), 64'd1);
            checkOutput("rot_idx",   64'(a4.gnt_idx),   64'(k % 4));
            checkOutput("n5_idx",    64'(a5.gnt_idx),   64'd4);
        end

        // Pointer at 2 after accepting idx 1: search wraps to idx 0
        $display("[TB] wrap-around search");
        pulse_reset("rst_a");
        r4 = 64'h2; rdy4 = 1'b1;
        applyStimulus();
        checkOutput("wrap_first", 64'(a4.gnt_idx), 64'd1);
        r4 = 64'h3;
        applyStimulus();
        checkOutput("wrap_idx",    64'(a4.gnt_idx),    64'd0);
        checkOutput("wrap_onehot", 64'(a4.gnt_onehot), 64'h1);

        // Hold under backpressure, then withdraw
        $display("[TB] hold and withdraw");
        pulse_reset("rst_b");
        r4 = 64'h4; rdy4 = 1'b0;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("hold_idx",   64'(a4.gnt_idx),   64'd2);
            checkOutput("hold_valid", 64'(a4.gnt_valid), 64'd1);
        end
        r4 = 64'h0;
        applyStimulus();
        checkOutput("wd_valid", 64'(a4.gnt_valid), 64'd0);
        checkOutput("wd_idx",   64'(a4.gnt_idx),   64'd2);
        r4 = 64'hF;
        applyStimulus();
        checkOutput("wd_ptr_idx", 64'(a4.gnt_idx), 64'd0);

`ifdef RR_ARB_LOCK_EN
        $display("[TB] bus lock");
        pulse_reset("rst_c");
        r4 = 64'h2; rdy4 = 1'b0; lk4 = 1'b0;
        applyStimulus();
        r4 = 64'hB; rdy4 = 1'b1; lk4 = 1'b1;
        applyStimulus();
        checkOutput("lock_locked", 64'(a4.locked),    64'd1);
        checkOutput("lock_valid",  64'(a4.gnt_valid), 64'd0);
        rdy4 = 1'b0; lk4 = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("lock_hold", 64'(a4.locked), 64'd1);
        r4 = 64'h9;
        applyStimulus();
        checkOutput("unlock", 64'(a4.locked), 64'd0);
        applyStimulus();
        checkOutput("after_lock_idx", 64'(a4.gnt_idx), 64'd3);

        r4 = 64'h2; rdy4 = 1'b1; lk4 = 1'b0;
        repeat (3) applyStimulus();
        lk4 = 1'b1;
        applyStimulus();
        checkOutput("relock", 64'(a4.locked), 64'd1);
        lk4 = 1'b0;
`endif

        // Reset mid-grant / mid-lock, then restart from pointer 0
        $display("[TB] reset while granted");
        r4 = 64'hF; rdy4 = 1'b0;
        applyStimulus();
        pulse_reset("rst_d");
        r4 = 64'h8;
        applyStimulus();
        checkOutput("post_rst_idx", 64'(a4.gnt_idx), 64'd3);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) r4[i] = ~r4[i];
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) r5[i] = ~r5[i];
            rdy4 = ($urandom_range(0, 2) != 0);
            rdy5 = ($urandom_range(0, 2) != 0);
            lk4  = ($urandom_range(0, 3) == 0);
            lk5  = ($urandom_range(0, 3) == 0);
            applyStimulus();
            if ($urandom_range(0, 249) == 0) pulse_reset("rst_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
